light_pixel_ingress: RTL and testbench

Front-end stage of the LightSeparator datapath. Accepts the raw RGB pixel stream driven by the test stimulus, or by the camera interface in silicon, over a valid/ready handshake. For each pixel it:
- computes an 8-bit-class luminance value;
- tags the pixel with frame coordinates and end-of-line/end-of-frame markers;
- buffers the result in a small FIFO that feeds the separator core.

It also detects frame-sync violations, so the core only ever sees well-formed frames.

---
 rtl/light_pixel_ingress_if.sv | 45 ++++
 rtl/light_pixel_ingress.sv | 178 +++++++++++++++++
 tb/tb_light_pixel_ingress.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/light_pixel_ingress_if.sv
// ============================================================================
//  Module      : light_pixel_ingress_if
//  Description : Pixel-in / tagged-pixel-out stream bundle for light_pixel_ingress.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface light_pixel_ingress_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
);
    localparam int c_XW = $clog2(IMG_W);
    localparam int c_YW = $clog2(IMG_H);

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic [DATA_W-1:0]     in_r;
    logic [DATA_W-1:0]     in_g;
    logic [DATA_W-1:0]     in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [3*DATA_W-1:0]   out_pixel;
    logic [DATA_W-1:0]     out_lum;
    logic [c_XW-1:0]       out_x;
    logic [c_YW-1:0]       out_y;
    logic                  out_eol;
    logic                  out_eof;
    logic                  err_sync;

    modport master (
        output in_valid, in_sof, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_pixel, out_lum, out_x, out_y,
               out_eol, out_eof, err_sync
    );

    modport slave (
        input  in_valid, in_sof, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_pixel, out_lum, out_x, out_y,
               out_eol, out_eof, err_sync
    );
endinterface

`default_nettype wire

// File: rtl/light_pixel_ingress.sv
// ============================================================================
//  Module      : light_pixel_ingress
//  Description : RGB ingress: luminance, frame tagging, sync checking, output FIFO.
//                Optional counters enabled by LS_INGRESS_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_pixel_ingress #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    light_pixel_ingress_if.slave bus
`ifdef LS_INGRESS_STATS_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt
`endif
);
    localparam int c_XW = $clog2(IMG_W);
    localparam int c_YW = $clog2(IMG_H);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = DATA_W + 8;
    localparam int c_EW = 4*DATA_W + c_XW + c_YW + 2;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_H - 1);
    localparam logic [c_AW:0]   c_DEPTH  = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_LW-1:0] c_KR     = c_LW'(77);
    localparam logic [c_LW-1:0] c_KG     = c_LW'(150);
    localparam logic [c_LW-1:0] c_KB     = c_LW'(29);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic              r_err;
    logic              r_stg_valid;
    logic [c_EW-1:0]   r_stg_data;
    logic [c_EW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic              w_fire;
    logic              w_drop;
    logic              w_viol;
    logic              w_take;
    logic              w_eol;
    logic              w_eof;
    logic [c_XW-1:0]   w_tag_x;
    logic [c_YW-1:0]   w_tag_y;
    logic [c_LW-1:0]   w_lum_acc;
    logic              w_pop;
    logic              w_fifo_wr;
    logic [c_EW-1:0]   w_head;

    assign w_fire = bus.in_valid && bus.in_ready;
    assign w_drop = w_fire && !bus.in_sof && (r_state == ST_IDLE);
    assign w_viol = w_fire && (bus.in_sof ? (r_state == ST_ACTIVE) : (r_state == ST_IDLE));
    assign w_take = w_fire && !w_drop;

    // A SOF pixel always restarts at (0,0), even when it truncates a frame
    assign w_tag_x = bus.in_sof ? '0 : r_x;
    assign w_tag_y = bus.in_sof ? '0 : r_y;
    assign w_eol   = !bus.in_sof && (r_state == ST_ACTIVE) && (r_x == c_X_LAST);
    assign w_eof   = w_eol && (r_y == c_Y_LAST);

    // Weights sum to 256, so the shifted result never exceeds the channel range
    assign w_lum_acc = c_KR * c_LW'(bus.in_r) + c_KG * c_LW'(bus.in_g) + c_KB * c_LW'(bus.in_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_viol;
            if (w_fire) begin
                if (bus.in_sof) begin
                    r_state <= ST_ACTIVE;
                    r_x     <= c_XW'(1);
                    r_y     <= '0;
                end else if (r_state == ST_ACTIVE) begin
                    if (w_eof) begin
                        r_state <= ST_IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else if (w_eol) begin
                        r_x <= '0;
                        r_y <= r_y + c_YW'(1);
                    end else begin
                        r_x <= r_x + c_XW'(1);
                    end
                end
            end
        end
    end

    // The stage register acts as one extra slot beyond the FIFO proper
    assign w_pop     = bus.out_valid && bus.out_ready;
    assign w_fifo_wr = r_stg_valid && ((r_count != c_DEPTH) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg_data  <= '0;
        end else if (w_take) begin
            r_stg_valid <= 1'b1;
            r_stg_data  <= {bus.in_r, bus.in_g, bus.in_b, w_lum_acc[c_LW-1:8],
                            w_tag_x, w_tag_y, w_eol, w_eof};
        end else if (w_fifo_wr) begin
            r_stg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= r_stg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + (c_AW+1)'(w_fifo_wr) - (c_AW+1)'(w_pop);
        end
    end

    assign bus.in_ready  = !((r_count == c_DEPTH) && r_stg_valid);
    assign bus.out_valid = (r_count != '0);
    assign w_head        = bus.out_valid ? r_mem[r_rd_ptr] : '0;
    assign {bus.out_pixel, bus.out_lum, bus.out_x, bus.out_y, bus.out_eol, bus.out_eof} = w_head;
    assign bus.err_sync  = r_err;

`ifdef LS_INGRESS_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_take && w_eof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_light_pixel_ingress.sv
// ============================================================================
//  Module      : tb_light_pixel_ingress
//  Description : Scoreboard bench for light_pixel_ingress (stats build via LS_INGRESS_STATS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_pixel_ingress;
    localparam int DATA_W     = 8;
    localparam int IMG_W      = 4;
    localparam int IMG_H      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int XW         = $clog2(IMG_W);
    localparam int YW         = $clog2(IMG_H);

    typedef struct packed {
        logic [3*DATA_W-1:0] pix;
        logic [DATA_W-1:0]   lum;
        logic [XW-1:0]       x;
        logic [YW-1:0]       y;
        logic                eol;
        logic                eof;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    light_pixel_ingress_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

`ifdef LS_INGRESS_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    light_pixel_ingress #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LS_INGRESS_STATS_EN
        ,
        .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    int          vectors     = 0;
    int          miscompares = 0;
    beat_t       sb[$];
    bit          m_in_frame  = 0;
    int          m_pos       = 0;
    logic [15:0] m_frames    = '0;
    int          m_drops     = 0;
    bit          err_sched   = 0;
    bit          err_due     = 0;
    int          err_seen    = 0;
    int          cyc         = 0;
    bit          lat_arm     = 0;
    int          lat_acc     = -1;
    bit          rnd_bp      = 0;
    bit          hold_prev   = 0;
    beat_t       prev_beat;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Frame position kept as a linear pixel index; coordinates derived arithmetically
    function automatic void model_accept(bit sof, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        beat_t e;
        int    l;
        if (sof) begin
            err_sched  = m_in_frame;
            m_in_frame = 1;
            m_pos      = 0;
        end else if (!m_in_frame) begin
            err_sched = 1;
            if (m_drops < 65535) m_drops++;
            return;
        end else begin
            err_sched = 0;
        end
        l     = (77*int'(r) + 150*int'(g) + 29*int'(b)) / 256;
        e.pix = {r, g, b};
        e.lum = DATA_W'(l);
        e.x   = XW'(m_pos % IMG_W);
        e.y   = YW'(m_pos / IMG_W);
        e.eol = (m_pos % IMG_W) == IMG_W - 1;
        e.eof = (m_pos == IMG_W*IMG_H - 1);
        sb.push_back(e);
        if (lat_arm && lat_acc < 0) lat_acc = cyc;
        m_pos++;
        if (e.eof) begin
            m_in_frame = 0;
            m_frames   = m_frames + 16'd1;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        err_due   = err_sched;
        err_sched = 0;
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: all DUT observation happens on the falling edge
    always @(negedge clk) begin
        beat_t got, exp;
        if (!rst) begin
            got = {bus.out_pixel, bus.out_lum, bus.out_x, bus.out_y, bus.out_eol, bus.out_eof};
            check("err_sync", bus.err_sync, err_due);
            if (bus.err_sync) err_seen++;
            if (lat_acc >= 0 && cyc == lat_acc + 1) check("latency_n1", bus.out_valid, 0);
            if (lat_acc >= 0 && cyc == lat_acc + 2) begin
                check("latency_n2", bus.out_valid, 1);
                lat_acc = -1;
                lat_arm = 0;
            end
            if (hold_prev && bus.out_valid) check("head_stable", got, prev_beat);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got %0h expected none", got);
                end else begin
                    exp = sb.pop_front();
                    check("out_beat", got, exp);
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_beat = got;
        end else begin
            hold_prev = 0;
        end
    end

    task automatic drive(bit sof, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        bus.in_sof   = sof;
        bus.in_r     = r;
        bus.in_g     = g;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(bit sof, logic [7:0] r, logic [7:0] g, logic [7:0] b);
        drive(sof, r, g, b);
        for (int w = 0; ; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(sof, r, g, b);
                break;
            end
            if (w > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: in_ready %0d expected 1", bus.in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        sb.delete();
        m_in_frame = 0;
        m_pos      = 0;
        m_frames   = '0;
        m_drops    = 0;
        err_sched  = 0;
        err_due    = 0;
        lat_arm    = 0;
        lat_acc    = -1;
    endtask

    task automatic drain(string name);
        for (int w = 0; w < 100 && sb.size() != 0; w++) idle(1);
        idle(2);
        check(name, sb.size(), 0);
    endtask

    // Streams with out_ready low until in_ready drops; returns accepted count
    task automatic fill(output int accepted);
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            drive(k == 0, 8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
            if (!bus.in_ready) break;
            model_accept(bus.in_sof, bus.in_r, bus.in_g, bus.in_b);
            accepted++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    logic [7:0] colours [8][3] = '{
        '{8'd255, 8'd255, 8'd255}, '{8'd255, 8'd0, 8'd0}, '{8'd0, 8'd255, 8'd0},
        '{8'd0, 8'd0, 8'd255}, '{8'd10, 8'd20, 8'd30}, '{8'd128, 8'd64, 8'd32},
        '{8'd0, 8'd0, 8'd0}, '{8'd1, 8'd2, 8'd3}};

    initial begin
        int acc;
        int e0;
        bit sof;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_r      = '0;
        bus.in_g      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        idle(2);
        do_reset();

        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_err_sync", bus.err_sync, 0);
        check("rst_out_fields", {bus.out_pixel, bus.out_lum, bus.out_x, bus.out_y,
                                 bus.out_eol, bus.out_eof}, 0);
`ifdef LS_INGRESS_STATS_EN
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        @(posedge clk);
        #1;

        // Back-to-back frame with the reference luminance colours
        lat_arm = 1;
        e0 = err_seen;
        for (int i = 0; i < 8; i++) send(i == 0, colours[i][0], colours[i][1], colours[i][2]);
        drain("frame_drain");
        check("frame_no_err", err_seen - e0, 0);

        // Non-SOF pixels straight after reset are dropped
        do_reset();
        e0 = err_seen;
        for (int i = 0; i < 3; i++) send(0, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(3);
        check("drop_err_pulses", err_seen - e0, 3);
        check("drop_out_valid", bus.out_valid, 0);
`ifdef LS_INGRESS_STATS_EN
        check("drop_cnt_3", drop_cnt, 3);
`endif

        // Premature SOF at pixel 5
        e0 = err_seen;
        for (int i = 0; i < 13; i++) send(i == 0 || i == 5, 8'($urandom), 8'($urandom), 8'($urandom));
        drain("presof_drain");
        check("presof_err_pulses", err_seen - e0, 1);

        // Backpressure: stage plus FIFO hold FIFO_DEPTH+1 pixels
        bus.out_ready = 1'b0;
        fill(acc);
        check("bp_accept_count", acc, FIFO_DEPTH + 1);
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(0, 8'($urandom), 8'($urandom), 8'($urandom));
        drain("bp_drain");

        // Reset mid-frame with the FIFO full
        bus.out_ready = 1'b0;
        fill(acc);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        e0 = err_seen;
        send(0, 8'd9, 8'd9, 8'd9);
        idle(3);
        check("midrst_drop_err", err_seen - e0, 1);
        check("midrst_out_valid2", bus.out_valid, 0);

        // Randomised traffic
        rnd_bp = 1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            sof = m_in_frame ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) != 0);
            send(sof, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        rnd_bp = 0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain("random_drain");
`ifdef LS_INGRESS_STATS_EN
        @(negedge clk);
        check("frame_cnt", frame_cnt, m_frames);
        check("drop_cnt", drop_cnt, m_drops);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time exceeded expected completion");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
